eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer.sv | 91 +++++++++
 tb/tb_eth_tx_framer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: MII Ethernet framer sending fixed-size frames from a double-buffered serial payload
module eth_tx_framer #(
  parameter logic [47:0] DEST_MAC = 48'h0000_0000_0000,
  parameter logic [47:0] SRC_MAC = 48'h0000_0000_0000,
  parameter logic [15:0] LEN_TYPE = 16'h0097,
  parameter int IFG_NIBBLES = 24
) (
  input logic phy_txclk,
  input logic rst_n,
  input logic ff_data,
  input logic ff_en,
  output logic [3:0] phy_txd,
  output logic phy_txen,
  output logic phy_txer,
  output logic need,
  output logic overflow,
  output logic [23:0] frameid
);
  localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, HEADER = 3'd2, PAYLOAD = 3'd3, CRC = 3'd4, IFG = 3'd5;
  logic [1183:0] bank [2];
  logic [1:0] full;
  logic wb, rb;
  logic [10:0] bit_cnt;
  logic [23:0] id_cnt;
  logic [2:0] state;
  logic [8:0] cnt;
  logic [31:0] crc, crc_nxt;
  logic [135:0] hdr;
  logic [3:0] nib;
  logic accept, wr_last, last, rel, go;
  assign phy_txer = 1'b0;
  assign accept = ff_en && !full[wb];
  assign wr_last = accept && bit_cnt == 11'd1183;
  assign last = cnt == (state == PREAMBLE ? 9'd15 : state == HEADER ? 9'd33 : state == PAYLOAD ? 9'd295 :
                        state == CRC ? 9'd7 : 9'(IFG_NIBBLES - 1));
  assign rel = state == CRC && last;
  assign go = full[rb] && (state == IDLE || (state == IFG && last));
  assign hdr = {frameid, LEN_TYPE, SRC_MAC, DEST_MAC};
  assign nib = state == PREAMBLE ? (last ? 4'hD : 4'h5) :
               state == HEADER ? hdr[{cnt[5:0], 2'b00} +: 4] :
               state == PAYLOAD ? bank[rb][{cnt, 2'b00} +: 4] :
               state == CRC ? ~crc[{cnt[2:0], 2'b00} +: 4] : 4'h0;
  // reflected CRC-32 advanced by the nibble on the wire, bit 0 first
  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 4; i++) crc_nxt = (crc_nxt >> 1) ^ ((crc_nxt[0] ^ nib[i]) ? 32'hEDB8_8320 : 32'h0);
  end
  // payload storage; contents survive reset since full flags gate their use
  always_ff @(posedge phy_txclk)
    if (accept) bank[wb][bit_cnt] <= ff_data;
  // bank bookkeeping: fill on the write side, release after the CRC, both may coincide
  always_ff @(posedge phy_txclk or negedge rst_n)
    if (!rst_n) begin
      wb <= 1'b0;
      rb <= 1'b0;
      bit_cnt <= 11'd0;
      full <= 2'b00;
      need <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (accept) bit_cnt <= wr_last ? 11'd0 : bit_cnt + 11'd1;
      if (wr_last) wb <= ~wb;
      if (rel) rb <= ~rb;
      full <= (full & ~(2'(rel) << rb)) | (2'(wr_last) << wb);
      need <= ~full[wb];
      if (ff_en && full[wb]) overflow <= 1'b1;
    end
  // frame sequencer with registered MII outputs
  always_ff @(posedge phy_txclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 9'd0;
      crc <= '1;
      frameid <= 24'd0;
      id_cnt <= 24'd0;
      phy_txd <= 4'h0;
      phy_txen <= 1'b0;
    end else begin
      phy_txen <= state inside {PREAMBLE, HEADER, PAYLOAD, CRC};
      phy_txd <= nib;
      crc <= (state == HEADER || state == PAYLOAD) ? crc_nxt : state == CRC ? crc : '1;
      cnt <= (state == IDLE || last) ? 9'd0 : cnt + 9'd1;
      if (go) begin
        frameid <= id_cnt;
        id_cnt <= id_cnt + 24'd1;
      end
      state <= state == IDLE ? (go ? PREAMBLE : IDLE) : !last ? state :
               state == PREAMBLE ? HEADER : state == HEADER ? PAYLOAD : state == PAYLOAD ? CRC :
               state == CRC ? IFG : go ? PREAMBLE : IDLE;
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed, table-driven checks of the MII frame framer
module tb_eth_tx_framer;
  logic phy_txclk = 1'b0, rst_n = 1'b0, ff_data = 1'b0, ff_en = 1'b0;
  logic [3:0] phy_txd;
  logic phy_txen, phy_txer, need, overflow;
  logic [23:0] frameid;
  int checks = 0, errors = 0;
  typedef struct { string name; int idx; logic [3:0] exp; } vec_t;
  vec_t tab [$];
  logic sent [$];
  logic [3:0] fr [8][$];
  int frames = 0, idle = 0, txd_bad = 0;
  int gaps [8];
  logic prev_en = 1'b0;

  eth_tx_framer #(.DEST_MAC(48'h1122_3344_5566), .SRC_MAC(48'hA1B2_C3D4_E5F6)) dut (
    .phy_txclk(phy_txclk), .rst_n(rst_n), .ff_data(ff_data), .ff_en(ff_en),
    .phy_txd(phy_txd), .phy_txen(phy_txen), .phy_txer(phy_txer),
    .need(need), .overflow(overflow), .frameid(frameid));

  always #20 phy_txclk = ~phy_txclk;

  // capture each frame's nibbles and the idle run preceding it
  always @(negedge phy_txclk) begin
    if (phy_txen) begin
      if (!prev_en && frames < 8) gaps[frames] = idle;
      if (frames < 8) fr[frames].push_back(phy_txd);
      idle = 0;
    end else begin
      if (phy_txd != 4'h0) txd_bad++;
      if (prev_en) frames++;
      idle++;
    end
    prev_en = phy_txen;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic restart();
    rst_n = 1'b0;
    ff_en = 1'b0;
    repeat (2) @(posedge phy_txclk);
    #1;
    frames = 0;
    idle = 0;
    txd_bad = 0;
    prev_en = 1'b0;
    foreach (fr[k]) fr[k].delete();
    sent.delete();
    rst_n = 1'b1;
    @(posedge phy_txclk);
    #1;
  endtask

  task automatic feed(int n, int mode, int burst);
    for (int i = 0; i < n; i++) begin
      ff_en = 1'b1;
      ff_data = mode == 0 ? ~i[0] : 1'($urandom);
      sent.push_back(ff_data);
      @(posedge phy_txclk);
      #1;
      if (burst != 0 && (i + 1) % burst == 0) begin
        ff_en = 1'b0;
        repeat (8) @(posedge phy_txclk);
        #1;
      end
    end
    ff_en = 1'b0;
  endtask

  task automatic wait_frames(string name, int n);
    for (int t = 0; t < 5000 && frames < n; t++) @(posedge phy_txclk);
    #1;
    chk({name, "_frame_count"}, frames, n);
  endtask

  task automatic check_frame(string name, int f, int base, logic [23:0] fid, bit do_id);
    logic [23:0] got_id;
    logic [31:0] c, got;
    logic [3:0] v;
    int bad;
    chk({name, "_len"}, fr[f].size(), 354);
    if (fr[f].size() != 354) return;
    foreach (tab[k]) chk({name, "_", tab[k].name}, fr[f][tab[k].idx], tab[k].exp);
    for (int k = 0; k < 6; k++) got_id[4*k +: 4] = fr[f][44+k];
    if (do_id) chk({name, "_frameid"}, got_id, fid);
    bad = 0;
    for (int n = 0; n < 296; n++) begin
      v = fr[f][50+n];
      for (int b = 0; b < 4; b++) if (v[b] !== sent[base+4*n+b]) bad++;
    end
    chk({name, "_payload_bad_bits"}, bad, 0);
    c = 32'hFFFF_FFFF;
    for (int n = 16; n < 346; n++) begin
      v = fr[f][n];
      for (int b = 0; b < 4; b++) c = (c >> 1) ^ ((c[0] ^ v[b]) ? 32'hEDB8_8320 : 32'h0);
    end
    for (int k = 0; k < 8; k++) got[4*k +: 4] = fr[f][346+k];
    chk({name, "_fcs"}, got, ~c);
  endtask

  initial begin
    tab.push_back('{"pre0", 0, 4'h5});
    tab.push_back('{"pre14", 14, 4'h5});
    tab.push_back('{"sfd", 15, 4'hD});
    tab.push_back('{"dst_n0", 16, 4'h6});
    tab.push_back('{"dst_n1", 17, 4'h6});
    tab.push_back('{"dst_n11", 27, 4'h1});
    tab.push_back('{"src_n0", 28, 4'h6});
    tab.push_back('{"src_n1", 29, 4'hF});
    tab.push_back('{"src_n11", 39, 4'hA});
    tab.push_back('{"len_n0", 40, 4'h7});
    tab.push_back('{"len_n1", 41, 4'h9});
    tab.push_back('{"len_n3", 43, 4'h0});

    // reset state
    repeat (2) @(negedge phy_txclk);
    chk("rst_txen", phy_txen, 0);
    chk("rst_txd", phy_txd, 0);
    chk("rst_txer", phy_txer, 0);
    chk("rst_need", need, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_frameid", frameid, 0);

    // one frame of alternating bits
    restart();
    feed(1184, 0, 0);
    wait_frames("alt", 1);
    check_frame("alt", 0, 0, 24'h0, 1);
    chk("alt_pay_first", fr[0].size() > 50 ? fr[0][50] : 4'hX, 4'h5);
    chk("alt_pay_last", fr[0].size() > 345 ? fr[0][345] : 4'hX, 4'h5);
    repeat (3) @(posedge phy_txclk);
    #1;
    chk("alt_need_after", need, 1);
    chk("alt_txd_idle_zero", txd_bad, 0);

    // two banks, contiguous input
    restart();
    feed(2368, 1, 0);
    wait_frames("two", 2);
    check_frame("two_f0", 0, 0, 24'h0, 1);
    check_frame("two_f1", 1, 1184, 24'h1, 1);
    chk("two_frameid_port", frameid, 24'h1);
    chk("two_txd_idle_zero", txd_bad, 0);

    // back-to-back frames: hold bank 1 marked full so the next frame follows the IFG directly
    restart();
    feed(1184, 1, 0);
    for (int t = 0; t < 2000 && fr[0].size() < 100; t++) @(negedge phy_txclk);
    chk("b2b_reach_payload", 32'(fr[0].size() >= 100), 1);
    force dut.full = 2'b11;
    for (int t = 0; t < 2000 && frames < 1; t++) @(negedge phy_txclk);
    force dut.full = 2'b10;
    for (int t = 0; t < 200 && fr[1].size() == 0; t++) @(negedge phy_txclk);
    release dut.full;
    wait_frames("b2b", 2);
    chk("b2b_gap", gaps[1], 24);
    chk("b2b_f1_len", fr[1].size(), 354);
    check_frame("b2b_f0", 0, 0, 24'h0, 1);

    // overflow: transmitter held idle so both banks fill
    restart();
    force dut.state = 3'd0;
    feed(1184, 1, 0);
    chk("ovf_need_one_full", need, 1);
    feed(1184, 1, 0);
    chk("ovf_need_lag", need, 1);
    @(posedge phy_txclk);
    #1;
    chk("ovf_need_both_full", need, 0);
    chk("ovf_not_yet", overflow, 0);
    feed(1185, 1, 0);
    chk("ovf_set", overflow, 1);
    release dut.state;
    wait_frames("ovf", 2);
    check_frame("ovf_f0", 0, 0, 24'h0, 0);
    check_frame("ovf_f1", 1, 1184, 24'h0, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_need_end", need, 1);

    // gapped bursts of 148 bits
    restart();
    feed(1184, 1, 148);
    wait_frames("burst", 1);
    check_frame("burst", 0, 0, 24'h0, 1);

    // reset during payload nibble 100
    restart();
    feed(1184, 1, 0);
    for (int t = 0; t < 2000 && fr[0].size() < 151; t++) @(negedge phy_txclk);
    chk("mid_txen_before", phy_txen, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_txen_async", phy_txen, 0);
    chk("mid_txd_async", phy_txd, 0);
    restart();
    feed(1184, 1, 0);
    wait_frames("mid", 1);
    check_frame("mid", 0, 0, 24'h0, 1);

    // frame ID wrap
    restart();
    force dut.id_cnt = 24'hFF_FFFF;
    @(posedge phy_txclk);
    #1;
    release dut.id_cnt;
    feed(2368, 1, 0);
    wait_frames("wrap", 2);
    check_frame("wrap_f0", 0, 0, 24'hFF_FFFF, 1);
    check_frame("wrap_f1", 1, 1184, 24'h00_0000, 1);
    chk("wrap_frameid_port", frameid, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
